alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Issue/writeback controller on the initiator side of the registered ALU interface (alu_op, din0, din1 -> dout).
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU, captures the ALU result one clock later, and writes it back to the register file.
- Sits between the instruction decoder and the ALU in the cpu datapath.

Parameters:
- NUM_REGS, 8, number of general registers in the internal register file.
- ADDR_W, 3, register index width; NUM_REGS must equal 2**ADDR_W.
- Data and opcode widths come from `BIT_DATA and `BIT_OP in definitions.v, not from parameters.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept an instruction
instr_op  in  `BIT_OP  ALU opcode (`INV..`DIV)
instr_rd  in  ADDR_W  destination register
instr_rs0  in  ADDR_W  source register for din0
instr_rs1  in  ADDR_W  source register for din1
instr_imm_sel  in  1  1: din1 = instr_imm instead of reg[rs1]
instr_imm  in  `BIT_DATA  immediate operand
alu_op  out  `BIT_OP  opcode to ALU
alu_din0  out  `BIT_DATA  operand 0 to ALU
alu_din1  out  `BIT_DATA  operand 1 to ALU
alu_dout  in  `BIT_DATA  registered ALU result
done  out  1  one-cycle pulse: writeback completed
result  out  `BIT_DATA  value written on last writeback
dbg_addr  in  ADDR_W  debug read index
dbg_data  out  `BIT_DATA  combinational reg[dbg_addr]

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All registers, alu_op, alu_din0, alu_din1, result cleared to 0.
  - done=0; instr_ready=1 once in IDLE.
- FSM has three states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge E0:
    - alu_op<=instr_op
    - alu_din0<=reg[rs0]
    - alu_din1<=imm_sel?imm:reg[rs1]
    - latch rd and op
    - go to ISSUE.
- ISSUE:
  - instr_ready=0; ALU inputs held stable.
  - The ALU samples them at edge E1; go to WB.
- WB:
  - instr_ready=0; alu_dout valid this cycle.
  - At E2: reg[rd]<=wbval, result<=wbval, done<=1, go to IDLE.
- wbval rules:
  - Equals alu_dout, except for `COM, where wbval = {zeros, alu_dout[2:0]}.
  - Zero-extension is required because the ALU leaves upper result bits stale on compare.
- done:
  - High exactly one cycle, the cycle after E2.
  - Deasserts at the next edge unless another writeback occurs; a back-to-back writeback is impossible, so done is always a single-cycle pulse.
- Latency and throughput:
  - Accept to done = 3 cycles.
  - Maximum throughput is 1 instruction per 3 cycles.
  - A new instruction may be accepted in the same cycle done is high.
- Operand hazard:
  - Operands are read at E0, after any prior writeback at the earlier E2.
  - Back-to-back dependent instructions therefore always see updated values; no bypass is needed.
- rd==rs0/rs1: the old value is used as the operand; the new value is written at E2.
- instr_* inputs are ignored when instr_ready=0; valid may stay high without effect.
- alu_op and alu_din* hold their last issued values in IDLE; the ALU result is ignored outside WB.
- Reset asserted during ISSUE or WB:
  - The instruction is abandoned; no register write and no done pulse.
  - The register file clears.
- dbg_data:
  - Purely combinational.
  - During the WB cycle it shows the old value; the new value is visible from the cycle after E2.

Optional Feature:
- Macro: ALU_DIVZ_GUARD_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - At accept, if instr_op==`DIV and the selected din1==0, the sequencer flags the instruction.
  - It still passes ISSUE and WB (same 3-cycle timing).
  - At E2: no register write, result<={`BIT_DATA{1'b1}}, done<=1, err<=1; err is a one-cycle pulse aligned with done.
  - For all other instructions, err stays 0.
- Undefined: no err port; divide-by-zero writes whatever alu_dout holds into rd.

Test Plan:
1. Reset then preload via immediate adds: ADD r1=r0+imm 5, ADD r2=r0+imm 3 -> done after 3 cycles each; dbg r1=5, r2=3.
2. SUB r3=r1-r2, then MUL r4=r3*r1 back-to-back with instr_valid held high -> r3=2, r4=10; instr_ready low for exactly 2 cycles per instruction.
3. COM r5=r1 vs r2 executed right after XOR r5=r1^r2 (=6) -> r5=0b100; upper bits cleared.
4. Assert reset for 1 cycle during ISSUE of ADD r6=r1+r2 -> no done; all registers 0; instr_ready=1 after reset release.
5. Randomised instr_valid gaps: 200 random ops (excluding DIV by 0) against a reference model -> register file matches and the done count equals the accept count.
6. (ALU_DIVZ_GUARD_EN) DIV r7=r1/imm 0 with r7 preloaded to 9 -> done and err together, result all ones, r7 still 9; without the macro, no err port exists.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller for a registered ALU.
// Accepts one instruction at a time, reads its operands from an internal
// register file, drives the ALU, then writes the ALU result back two edges later.
// Optional feature macro: ALU_DIVZ_GUARD_EN adds an err output. Flagged
// divide-by-zero instructions then complete without a register write.

`ifndef BIT_DATA
`define BIT_DATA 16
`endif
`ifndef BIT_OP
`define BIT_OP 4
`endif
`ifndef INV
`define INV 4'd0
`define ADD 4'd1
`define SUB 4'd2
`define MUL 4'd3
`define AND 4'd4
`define OR  4'd5
`define XOR 4'd6
`define COM 4'd7
`define DIV 4'd8
`endif

module alu_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [`BIT_OP-1:0]   instr_op,
    input  logic [ADDR_W-1:0]    instr_rd,
    input  logic [ADDR_W-1:0]    instr_rs0,
    input  logic [ADDR_W-1:0]    instr_rs1,
    input  logic                 instr_imm_sel,
    input  logic [`BIT_DATA-1:0] instr_imm,
    output logic [`BIT_OP-1:0]   alu_op,
    output logic [`BIT_DATA-1:0] alu_din0,
    output logic [`BIT_DATA-1:0] alu_din1,
    input  logic [`BIT_DATA-1:0] alu_dout,
    output logic                 done,
    output logic [`BIT_DATA-1:0] result,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [`BIT_DATA-1:0] dbg_data
`ifdef ALU_DIVZ_GUARD_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t               state;
    logic [`BIT_DATA-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0]    wb_rd_p0;
    logic [`BIT_OP-1:0]   wb_op_p0;
    logic [`BIT_DATA-1:0] opnd1;
    logic [`BIT_DATA-1:0] wbval;
    logic                 wr_en;
`ifdef ALU_DIVZ_GUARD_EN
    logic                 divz_p0;
`endif

    // The ALU leaves stale upper bits on compare; only the 3 flag bits are meaningful.
    function automatic logic [`BIT_DATA-1:0] wb_value(input logic [`BIT_OP-1:0]   op,
                                                      input logic [`BIT_DATA-1:0] dout);
        if (op == `COM)
            return {{(`BIT_DATA-3){1'b0}}, dout[2:0]};
        return dout;
    endfunction

    // Operand 1 source select, writeback value and write enable.
    always_comb begin
        opnd1    = instr_imm_sel ? instr_imm : regs[instr_rs1];
        wbval    = wb_value(wb_op_p0, alu_dout);
        wr_en    = (state == WB);
`ifdef ALU_DIVZ_GUARD_EN
        if (divz_p0)
            wr_en = 1'b0;
`endif
        dbg_data = regs[dbg_addr];
    end

    // Control FSM: accept in IDLE, let the ALU sample in ISSUE, write back in WB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            alu_op      <= '0;
            alu_din0    <= '0;
            alu_din1    <= '0;
            result      <= '0;
            done        <= 1'b0;
            wb_rd_p0    <= '0;
            wb_op_p0    <= '0;
`ifdef ALU_DIVZ_GUARD_EN
            divz_p0     <= 1'b0;
            err         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ALU_DIVZ_GUARD_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_op      <= instr_op;
                        alu_din0    <= regs[instr_rs0];
                        alu_din1    <= opnd1;
                        wb_rd_p0    <= instr_rd;
                        wb_op_p0    <= instr_op;
`ifdef ALU_DIVZ_GUARD_EN
                        divz_p0     <= (instr_op == `DIV) && (opnd1 == '0);
`endif
                        instr_ready <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WB;
                end
                WB: begin
                    result      <= wbval;
`ifdef ALU_DIVZ_GUARD_EN
                    if (divz_p0)
                        result  <= {`BIT_DATA{1'b1}};
                    err         <= divz_p0;
`endif
                    done        <= 1'b1;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written once per completed instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_rd_p0] <= wbval;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomised bench for alu_sequencer with a behavioural registered ALU.

`ifndef BIT_DATA
`define BIT_DATA 16
`endif
`ifndef BIT_OP
`define BIT_OP 4
`endif
`ifndef INV
`define INV 4'd0
`define ADD 4'd1
`define SUB 4'd2
`define MUL 4'd3
`define AND 4'd4
`define OR  4'd5
`define XOR 4'd6
`define COM 4'd7
`define DIV 4'd8
`endif

module tb_alu_sequencer;

    localparam int W  = `BIT_DATA;
    localparam int AW = 3;

    logic              clock, reset;
    logic              instr_valid, instr_ready;
    logic [`BIT_OP-1:0] instr_op;
    logic [AW-1:0]     instr_rd, instr_rs0, instr_rs1;
    logic              instr_imm_sel;
    logic [W-1:0]      instr_imm;
    logic [`BIT_OP-1:0] alu_op;
    logic [W-1:0]      alu_din0, alu_din1, alu_dout;
    logic              done;
    logic [W-1:0]      result;
    logic [AW-1:0]     dbg_addr;
    logic [W-1:0]      dbg_data;
`ifdef ALU_DIVZ_GUARD_EN
    logic              err;
`endif

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int n_done = 0;
    logic [W-1:0] mregs [8];

    alu_sequencer #(.NUM_REGS(8), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
        .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
        .alu_op(alu_op), .alu_din0(alu_din0), .alu_din1(alu_din1),
        .alu_dout(alu_dout), .done(done), .result(result),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_DIVZ_GUARD_EN
        , .err(err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered ALU; compare sets only the 3 flag bits and leaves junk above.
    function automatic logic [W-1:0] alu_f(input logic [`BIT_OP-1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            `INV: return ~a;
            `ADD: return a + b;
            `SUB: return a - b;
            `MUL: return a * b;
            `AND: return a & b;
            `OR:  return a | b;
            `XOR: return a ^ b;
            `COM: return {{(W-3){1'b1}}, a > b, a == b, a < b};
            `DIV: return (b == '0) ? '0 : a / b;
            default: return '0;
        endcase
    endfunction

    // Value the register file must receive.
    function automatic logic [W-1:0] exp_f(input logic [`BIT_OP-1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] v;
        v = alu_f(op, a, b);
        if (op == `COM)
            v = {{(W-3){1'b0}}, v[2:0]};
        return v;
    endfunction

    always @(posedge clock) alu_dout <= alu_f(alu_op, alu_din0, alu_din1);

    always @(posedge clock) begin
        if (!reset) begin
            if (instr_valid && instr_ready) n_acc++;
            if (done) n_done++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run_instr(input logic [`BIT_OP-1:0] op, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                             input logic sel, input logic [W-1:0] imm, input bit keep);
        int waitc;
        int cyc;
        int lows;
        logic [W-1:0] a, b, expv;
        logic [31:0] r;
        bit dz;
        waitc = 0;
        while (!instr_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        check_eq("ready_before_issue", 32'(instr_ready), 32'd1);
        a = mregs[rs0];
        b = sel ? imm : mregs[rs1];
        expv = exp_f(op, a, b);
        dz = 1'b0;
`ifdef ALU_DIVZ_GUARD_EN
        dz = (op == `DIV) && (b == '0);
`endif
        instr_op = op; instr_rd = rd; instr_rs0 = rs0; instr_rs1 = rs1;
        instr_imm_sel = sel; instr_imm = imm; instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (keep) begin
            r = $urandom;
            instr_op = r[3:0]; instr_rd = r[6:4]; instr_rs0 = r[9:7];
            instr_rs1 = r[12:10]; instr_imm_sel = r[13]; instr_imm = r[31:16];
        end else begin
            instr_valid = 1'b0;
        end
        dbg_addr = rd;
        cyc = 1;
        lows = 0;
        while (!done && cyc < 8) begin
            if (!instr_ready) lows++;
            if (cyc == 2) check_eq("dbg_old_in_wb", 32'(dbg_data), 32'(mregs[rd]));
            @(negedge clock);
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'd3);
        check_eq("ready_low_cycles", 32'(lows), 32'd2);
        check_eq("ready_with_done", 32'(instr_ready), 32'd1);
        if (dz) begin
            check_eq("divz_result", 32'(result), 32'(16'hFFFF));
            check_eq("divz_reg_kept", 32'(dbg_data), 32'(mregs[rd]));
        end else begin
            mregs[rd] = expv;
            check_eq("wb_result", 32'(result), 32'(expv));
            check_eq("wb_reg", 32'(dbg_data), 32'(expv));
        end
`ifdef ALU_DIVZ_GUARD_EN
        check_eq("err_flag", 32'(err), 32'(dz));
`endif
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] idx, input logic [W-1:0] exp);
        dbg_addr = idx;
        #1;
        check_eq(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [`BIT_OP-1:0] rop;
        reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs0 = '0; instr_rs1 = '0; instr_imm_sel = 1'b0; instr_imm = '0;
        dbg_addr = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        repeat (2) @(negedge clock);
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        check_reg("rst_r3", 3'd3, 16'd0);
        reset = 1'b0;
        @(negedge clock);

        // Preload through immediate adds.
        run_instr(`ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 1'b0);
        check_reg("r1_is_5", 3'd1, 16'd5);
        run_instr(`ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, 1'b0);
        check_reg("r2_is_3", 3'd2, 16'd3);
        @(negedge clock);
        check_eq("done_single_pulse", 32'(done), 32'd0);

        // Dependent back-to-back with valid held high and junk fields while busy.
        run_instr(`SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b1);
        run_instr(`MUL, 3'd4, 3'd3, 3'd1, 1'b0, 16'd0, 1'b0);
        check_reg("r3_is_2", 3'd3, 16'd2);
        check_reg("r4_is_10", 3'd4, 16'd10);

        // Compare result must be zero-extended.
        run_instr(`XOR, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0);
        check_reg("r5_xor_6", 3'd5, 16'd6);
        run_instr(`COM, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0);
        check_reg("r5_com_4", 3'd5, 16'd4);

`ifdef ALU_DIVZ_GUARD_EN
        run_instr(`ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'd9, 1'b0);
        run_instr(`DIV, 3'd7, 3'd1, 3'd0, 1'b1, 16'd0, 1'b0);
        check_eq("divz_done", 32'(done), 32'd1);
        check_reg("r7_still_9", 3'd7, 16'd9);
`endif

        // Reset during ISSUE abandons the instruction and clears the file.
        @(negedge clock);
        instr_op = `ADD; instr_rd = 3'd6; instr_rs0 = 3'd1; instr_rs1 = 3'd2;
        instr_imm_sel = 1'b0; instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        check_eq("in_issue_ready", 32'(instr_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("async_rst_ready", 32'(instr_ready), 32'd1);
        check_eq("async_rst_result", 32'(result), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("no_done_after_rst", 32'(done), 32'd0);
            @(negedge clock);
        end
        check_eq("ready_after_rst", 32'(instr_ready), 32'd1);
        check_eq("din0_after_rst", 32'(alu_din0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            mregs[i] = '0;
            check_reg("regs_cleared", 3'(i), 16'd0);
        end

        // Random traffic with gaps.
        n_acc = 0;
        n_done = 0;
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            repeat (r[31:30]) @(negedge clock);
            case (r[3:0] % 9)
                0: rop = `INV;
                1: rop = `ADD;
                2: rop = `SUB;
                3: rop = `MUL;
                4: rop = `AND;
                5: rop = `OR;
                6: rop = `XOR;
                7: rop = `COM;
                default: rop = `DIV;
            endcase
            if (rop == `DIV && ((r[13] ? r[29:14] : mregs[r[12:10]]) == '0))
                rop = `ADD;
            run_instr(rop, r[6:4], r[9:7], r[12:10], r[13], r[29:14], 1'b0);
        end
        repeat (3) @(negedge clock);
        check_eq("done_count", 32'(n_done), 32'(n_acc));
        for (int i = 0; i < 8; i++)
            check_reg("final_regs", 3'(i), mregs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
